sram_arbiter: RTL and testbench

- Shares the single external 16-bit async SRAM between two requesters:
  - the video scan-out fetcher, a high-priority pipelined read-only port;
  - the CPU host port, read/write, one access outstanding at a time.
- Sits between the SoC core and the pad-level SRAM glue.
- Drives the registered SRAM address, write-enable and write data. Write strobe timing (quadrature clock) stays in the top level.
- Guarantees CPU forward progress with a bounded-wait counter.

---
 rtl/sram_arbiter.sv | 112 +++++++++++
 tb/tb_sram_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async SRAM between a pipelined video read port and a CPU host port.
// Optional macro SRAM_ARB_TURNAROUND_EN forces an idle slot after every write slot.
module sram_arbiter #(
   parameter int AW           = 13,
   parameter int DW           = 16,
   parameter int CPU_MAX_WAIT = 4
) (
   input  logic          clk_core,
   input  logic          reset_n,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_gnt,
   output logic          vid_ack,
   output logic [DW-1:0] vid_rdata,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   output logic [AW-1:0] sram_a,
   output logic          sram_wr,
   output logic [DW-1:0] host_to_sram,
   input  logic [DW-1:0] sram_to_host
);

   localparam int            WW       = (CPU_MAX_WAIT < 1) ? 1 : $clog2(CPU_MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(CPU_MAX_WAIT);
   localparam logic          OWN_VID  = 1'b0;
   localparam logic          OWN_CPU  = 1'b1;

   logic          cpu_busy;
   logic [WW-1:0] wait_cnt;
   logic          b_valid;
   logic          b_owner;
   logic          force_idle;
   logic          cpu_elig;
   logic          cpu_force;
   logic          cpu_gnt;

`ifdef SRAM_ARB_TURNAROUND_EN
   // The slot after a driven write is left empty so the bus can turn around.
   assign force_idle = sram_wr;
`else
   assign force_idle = 1'b0;
`endif

   always_comb begin
      cpu_elig  = cpu_req & ~cpu_busy;
      cpu_force = cpu_elig & (wait_cnt == WAIT_MAX);
      vid_gnt   = ~force_idle & vid_req & ~cpu_force;
      cpu_gnt   = ~force_idle & cpu_elig & (cpu_force | ~vid_req);
   end

   // Stage B: register the winner onto the SRAM bus; idle slots keep the last address.
   always_ff @(posedge clk_core or negedge reset_n) begin
      if (!reset_n) begin
         sram_a       <= '0;
         sram_wr      <= 1'b0;
         host_to_sram <= '0;
         b_valid      <= 1'b0;
         b_owner      <= OWN_VID;
      end else begin
         b_valid <= vid_gnt | cpu_gnt;
         b_owner <= cpu_gnt ? OWN_CPU : OWN_VID;
         sram_wr <= cpu_gnt & cpu_we;
         if (cpu_gnt) begin
            sram_a <= cpu_addr;
            if (cpu_we)
               host_to_sram <= cpu_wdata;
         end else if (vid_gnt) begin
            sram_a <= vid_addr;
         end
      end
   end

   // Stage C: capture read data for the slot owner and pulse its ack.
   always_ff @(posedge clk_core or negedge reset_n) begin
      if (!reset_n) begin
         vid_ack   <= 1'b0;
         cpu_ack   <= 1'b0;
         vid_rdata <= '0;
         cpu_rdata <= '0;
      end else begin
         vid_ack <= b_valid & (b_owner == OWN_VID);
         cpu_ack <= b_valid & (b_owner == OWN_CPU);
         if (b_valid && b_owner == OWN_VID)
            vid_rdata <= sram_to_host;
         if (b_valid && b_owner == OWN_CPU && !sram_wr)
            cpu_rdata <= sram_to_host;
      end
   end

   always_ff @(posedge clk_core or negedge reset_n) begin
      if (!reset_n) begin
         cpu_busy <= 1'b0;
         wait_cnt <= '0;
      end else begin
         if (cpu_gnt)
            cpu_busy <= 1'b1;
         else if (cpu_ack)
            cpu_busy <= 1'b0;

         // Count only slots the CPU actually lost to video, saturating at the limit.
         if (cpu_gnt || !cpu_elig)
            wait_cnt <= '0;
         else if (!force_idle && wait_cnt != WAIT_MAX)
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: per-cycle request table with expected winners; a scoreboard
// checks the registered SRAM bus one cycle later and the acks/read data two cycles later.
`timescale 1ns/1ps
module tb_sram_arbiter;

   localparam int AW    = 13;
   localparam int DW    = 16;
   localparam int W_IDLE = 0;
   localparam int W_VID  = 1;
   localparam int W_CPU  = 2;

   logic          clk_core = 1'b0;
   logic          reset_n  = 1'b0;
   logic          vid_req  = 1'b0;
   logic [AW-1:0] vid_addr = '0;
   logic          vid_gnt;
   logic          vid_ack;
   logic [DW-1:0] vid_rdata;
   logic          cpu_req   = 1'b0;
   logic          cpu_we    = 1'b0;
   logic [AW-1:0] cpu_addr  = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;
   logic [AW-1:0] sram_a;
   logic          sram_wr;
   logic [DW-1:0] host_to_sram;
   logic [DW-1:0] sram_to_host;

   always #5 clk_core = ~clk_core;

   sram_arbiter #(.AW(AW), .DW(DW), .CPU_MAX_WAIT(4)) dut (
      .clk_core    (clk_core),
      .reset_n     (reset_n),
      .vid_req     (vid_req),
      .vid_addr    (vid_addr),
      .vid_gnt     (vid_gnt),
      .vid_ack     (vid_ack),
      .vid_rdata   (vid_rdata),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_ack     (cpu_ack),
      .cpu_rdata   (cpu_rdata),
      .sram_a      (sram_a),
      .sram_wr     (sram_wr),
      .host_to_sram(host_to_sram),
      .sram_to_host(sram_to_host)
   );

   // Pad-level async SRAM: unwritten words return a fixed address pattern.
   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      if (a == 13'h0123) return 16'hBEEF;
      return {3'b000, a} ^ 16'hC3A5;
   endfunction

   bit            wr_seen [0:(1<<AW)-1];
   logic [DW-1:0] wr_data [0:(1<<AW)-1];
   assign sram_to_host = wr_seen[sram_a] ? wr_data[sram_a] : pat(sram_a);
   always @(posedge clk_core) begin
      if (sram_wr) begin
         wr_seen[sram_a] <= 1'b1;
         wr_data[sram_a] <= host_to_sram;
      end
   end

   // Expected memory contents, updated when a write is granted.
   bit            sh_seen [0:(1<<AW)-1];
   logic [DW-1:0] sh_data [0:(1<<AW)-1];
   function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a);
      return sh_seen[a] ? sh_data[a] : pat(a);
   endfunction

   typedef struct {
      bit            vreq;
      logic [AW-1:0] vaddr;
      bit            creq;
      bit            cwe;
      logic [AW-1:0] caddr;
      logic [DW-1:0] cwdata;
      int            win;
   } vec_t;

   typedef struct {
      int            due;
      int            kind;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } sb_t;

   vec_t tbl[$];
   sb_t  busq[$];
   sb_t  ackq[$];

   int            cyc   = 0;
   int            n_vec = 0;
   int            n_err = 0;
   logic [AW-1:0] exp_a   = '0;
   logic [DW-1:0] exp_vrd = '0;
   logic [DW-1:0] exp_crd = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, req);
      end
   endtask

   function automatic vec_t mk(input bit vreq, input logic [AW-1:0] vaddr, input bit creq,
                               input bit cwe, input logic [AW-1:0] caddr,
                               input logic [DW-1:0] cwdata, input int win);
      vec_t v;
      v.vreq = vreq; v.vaddr = vaddr; v.creq = creq; v.cwe = cwe;
      v.caddr = caddr; v.cwdata = cwdata; v.win = win;
      return v;
   endfunction

   function automatic vec_t idle_row();
      return mk(1'b0, '0, 1'b0, 1'b0, '0, '0, W_IDLE);
   endfunction

   task automatic tick();
      @(posedge clk_core);
      #1;
      cyc++;
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_sram_a"},       32'(sram_a),       32'd0);
      chk({tag, "_sram_wr"},      32'(sram_wr),      32'd0);
      chk({tag, "_host_to_sram"}, 32'(host_to_sram), 32'd0);
      chk({tag, "_vid_ack"},      32'(vid_ack),      32'd0);
      chk({tag, "_cpu_ack"},      32'(cpu_ack),      32'd0);
      chk({tag, "_vid_rdata"},    32'(vid_rdata),    32'd0);
      chk({tag, "_cpu_rdata"},    32'(cpu_rdata),    32'd0);
      chk({tag, "_vid_gnt"},      32'(vid_gnt),      32'd0);
   endtask

   task automatic check_pipe();
      sb_t e;
      bit  ev;
      bit  ec;
      ev = 1'b0;
      ec = 1'b0;
      if (busq.size() > 0 && busq[0].due == cyc) begin
         e = busq.pop_front();
         chk("sram_wr", 32'(sram_wr), 32'(e.we));
         if (e.kind != W_IDLE) exp_a = e.addr;
         chk("sram_a", 32'(sram_a), 32'(exp_a));
         if (e.we) chk("host_to_sram", 32'(host_to_sram), 32'(e.data));
      end
      if (ackq.size() > 0 && ackq[0].due == cyc) begin
         e = ackq.pop_front();
         if (e.kind == W_VID) begin
            ev = 1'b1;
            exp_vrd = e.data;
         end else begin
            ec = 1'b1;
            if (!e.we) exp_crd = e.data;
         end
      end
      chk("vid_ack",   32'(vid_ack),   32'(ev));
      chk("cpu_ack",   32'(cpu_ack),   32'(ec));
      chk("vid_rdata", 32'(vid_rdata), 32'(exp_vrd));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_crd));
   endtask

   task automatic apply(input vec_t v);
      sb_t e;
      tick();
      vid_req   = v.vreq;
      vid_addr  = v.vaddr;
      cpu_req   = v.creq;
      cpu_we    = v.cwe;
      cpu_addr  = v.caddr;
      cpu_wdata = v.cwdata;
      @(negedge clk_core);
      check_pipe();
      chk("vid_gnt", 32'(vid_gnt), 32'(v.win == W_VID));
      e.due  = cyc + 1;
      e.kind = v.win;
      e.we   = (v.win == W_CPU) && v.cwe;
      e.addr = (v.win == W_CPU) ? v.caddr : v.vaddr;
      e.data = v.cwdata;
      busq.push_back(e);
      if (v.win != W_IDLE) begin
         e.due = cyc + 2;
         if (e.we) begin
            sh_seen[e.addr] = 1'b1;
            sh_data[e.addr] = v.cwdata;
         end else begin
            e.data = exp_word(e.addr);
         end
         ackq.push_back(e);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk_core);
      #1;
      check_outputs_zero("reset");
      @(negedge clk_core);
      reset_n = 1'b1;

      // Single CPU read; address change after grant must be ignored.
      tbl.push_back(mk(1'b0, '0, 1'b1, 1'b0, 13'h0123, 16'h0000, W_CPU));
      tbl.push_back(mk(1'b0, '0, 1'b1, 1'b0, 13'h0456, 16'h0000, W_IDLE));
      tbl.push_back(mk(1'b0, '0, 1'b1, 1'b0, 13'h0456, 16'h0000, W_IDLE));
      tbl.push_back(idle_row());
      // CPU write at the top address, then read it back.
      tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 13'h1FFF, 16'hA5A5, W_CPU));
      tbl.push_back(mk(1'b0, '0, 1'b1, 1'b0, 13'h0002, 16'h0000, W_IDLE));
      tbl.push_back(mk(1'b0, '0, 1'b1, 1'b0, 13'h0002, 16'h0000, W_IDLE));
      tbl.push_back(idle_row());
      tbl.push_back(mk(1'b0, '0, 1'b1, 1'b0, 13'h1FFF, 16'h0000, W_CPU));
      tbl.push_back(mk(1'b0, '0, 1'b1, 1'b0, 13'h1FFF, 16'h0000, W_IDLE));
      tbl.push_back(mk(1'b0, '0, 1'b1, 1'b0, 13'h1FFF, 16'h0000, W_IDLE));
      tbl.push_back(idle_row());
      // Simultaneous first requests: video first, CPU next.
      tbl.push_back(mk(1'b1, 13'h0010, 1'b1, 1'b0, 13'h0020, 16'h0000, W_VID));
      tbl.push_back(mk(1'b0, '0,       1'b1, 1'b0, 13'h0020, 16'h0000, W_CPU));
      tbl.push_back(mk(1'b0, '0,       1'b1, 1'b0, 13'h0020, 16'h0000, W_IDLE));
      tbl.push_back(mk(1'b0, '0,       1'b1, 1'b0, 13'h0020, 16'h0000, W_IDLE));
      tbl.push_back(idle_row());
      // Video saturation with CPU pending: CPU forced in on the 5th contended cycle.
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(1'b1, 13'(i), 1'b1, 1'b0, 13'h0ABC, 16'h0000, W_VID));
      tbl.push_back(mk(1'b1, 13'd4, 1'b1, 1'b0, 13'h0ABC, 16'h0000, W_CPU));
      tbl.push_back(mk(1'b1, 13'd4, 1'b1, 1'b0, 13'h0ABC, 16'h0000, W_VID));
      tbl.push_back(mk(1'b1, 13'd5, 1'b1, 1'b0, 13'h0ABC, 16'h0000, W_VID));
      for (int i = 6; i < 16; i++)
         tbl.push_back(mk(1'b1, 13'(i), 1'b0, 1'b0, '0, 16'h0000, W_VID));
      for (int i = 0; i < 3; i++)
         tbl.push_back(idle_row());

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i]);

      // CPU write followed by continuous video requests.
      apply(mk(1'b0, '0, 1'b1, 1'b1, 13'h0300, 16'h1234, W_CPU));
`ifdef SRAM_ARB_TURNAROUND_EN
      apply(mk(1'b1, 13'h0041, 1'b1, 1'b0, 13'h0300, 16'h0000, W_IDLE));
      apply(mk(1'b1, 13'h0041, 1'b1, 1'b0, 13'h0300, 16'h0000, W_VID));
      apply(mk(1'b1, 13'h0042, 1'b0, 1'b0, '0,       16'h0000, W_VID));
`else
      apply(mk(1'b1, 13'h0041, 1'b1, 1'b0, 13'h0300, 16'h0000, W_VID));
      apply(mk(1'b1, 13'h0042, 1'b1, 1'b0, 13'h0300, 16'h0000, W_VID));
      apply(mk(1'b1, 13'h0043, 1'b0, 1'b0, '0,       16'h0000, W_VID));
`endif
      for (int i = 0; i < 3; i++)
         apply(idle_row());

      // Reset the cycle after a CPU grant: the in-flight read is dropped.
      apply(mk(1'b0, '0, 1'b1, 1'b0, 13'h0777, 16'h0000, W_CPU));
      tick();
      reset_n   = 1'b0;
      vid_req   = 1'b0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      #1;
      check_outputs_zero("midreset");
      busq.delete();
      ackq.delete();
      exp_a   = '0;
      exp_vrd = '0;
      exp_crd = '0;
      tick();
      tick();
      @(negedge clk_core);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++)
         apply(idle_row());
      apply(mk(1'b0, '0, 1'b1, 1'b0, 13'h0123, 16'h0000, W_CPU));
      apply(mk(1'b0, '0, 1'b1, 1'b0, 13'h0123, 16'h0000, W_IDLE));
      apply(mk(1'b0, '0, 1'b1, 1'b0, 13'h0123, 16'h0000, W_IDLE));
      apply(idle_row());
      apply(idle_row());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
